i2c_slave_regbank: RTL and testbench

- Parametrised successor to the single-byte I2C slave application driver.
- Sits between the I2C slave byte core and the user logic, and exposes a bank of NREGS 8-bit registers over I2C.
- I2C access uses a register-pointer protocol: on a write transaction the first byte is the pointer and the following bytes are data; reads return data from the pointer. The pointer auto-increments.
- A host-side port gives user logic read/write access to the same registers.

---
 rtl/i2c_slave_regbank.sv | 154 +++++++++++++++
 tb/tb_i2c_slave_regbank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: bank of NREGS 8-bit registers exposed over an I2C slave
// byte core using a register-pointer protocol, plus a host-side access port.
// Ports:
//   clk, reset                 - clock (logic on negedge), synchronous active-high reset
//   address                    - constant slave address
//   transfer_start/transfer_rw - START with address match, R/W bit
//   datareceive/received       - received byte and its toggle-high strobe level
//   datasend/sended            - byte offered for reads, shifted-out indication
//   host_we/addr/wdata/rdata   - host register port (1-cycle read latency)
//   wr_valid/wr_index          - pulse on each accepted I2C register write
//   err/err_clr                - sticky error flag and its clear
module i2c_slave_regbank #(
  parameter logic [6:0]       SLAVE_ADDRESS = 7'h50,
  parameter int unsigned      NREGS         = 16,
  parameter bit               AUTO_INC      = 1'b1,
  parameter bit               WRAP          = 1'b1,
  parameter logic [NREGS-1:0] RO_MASK       = '0,
  localparam int unsigned     PW            = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [6:0]    address,
  input  logic          transfer_start,
  input  logic          transfer_rw,
  input  logic [7:0]    datareceive,
  input  logic          received,
  output logic [7:0]    datasend,
  input  logic          sended,
  input  logic          host_we,
  input  logic [PW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          wr_valid,
  output logic [PW-1:0] wr_index,
  output logic          err,
  input  logic          err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PTR   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    regs_q [NREGS];
  logic [7:0]    regs_d [NREGS];
  logic [7:0]    datasend_q, datasend_d;
  logic [7:0]    host_rdata_q, host_rdata_d;
  logic          wr_valid_q, wr_valid_d;
  logic [PW-1:0] wr_index_q, wr_index_d;
  logic          err_q, err_d;
  logic          last_received_q, last_received_d;
  logic          last_sended_q, last_sended_d;
  logic          rx_ev, tx_ev, err_set;

  assign address = SLAVE_ADDRESS;

  // Pointer advance after a data byte: hold, increment, wrap or saturate.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (!AUTO_INC) return p;
    if (p == PW'(NREGS - 1)) return WRAP ? '0 : p;
    return p + PW'(1);
  endfunction

  assign rx_ev = received & ~last_received_q;
  assign tx_ev = sended & ~last_sended_q;

  // Next-state and register-update logic.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    regs_d          = regs_q;
    wr_valid_d      = 1'b0;
    wr_index_d      = wr_index_q;
    err_set         = 1'b0;
    last_received_d = received;
    last_sended_d   = sended;
    datasend_d      = regs_q[ptr_q];
    host_rdata_d    = regs_q[host_addr];

    // Host write first so that an I2C write to the same index overrides it.
    if (host_we) regs_d[host_addr] = host_wdata;

    if (transfer_start) begin
      state_d = transfer_rw ? ST_READ : ST_PTR;
    end else begin
      case (state_q)
        ST_PTR: begin
          if (rx_ev) begin
            if ({1'b0, datareceive} < 9'(NREGS)) ptr_d = datareceive[PW-1:0];
            else err_set = 1'b1;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (rx_ev) begin
            if (!RO_MASK[ptr_q]) begin
              regs_d[ptr_q] = datareceive;
              wr_valid_d    = 1'b1;
              wr_index_d    = ptr_q;
            end else begin
              err_set = 1'b1;
            end
            ptr_d = next_ptr(ptr_q);
          end
        end
        ST_READ: begin
          if (tx_ev) ptr_d = next_ptr(ptr_q);
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A new error outranks a simultaneous clear.
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // State and output registers.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      regs_q          <= '{default: '0};
      datasend_q      <= '0;
      host_rdata_q    <= '0;
      wr_valid_q      <= 1'b0;
      wr_index_q      <= '0;
      err_q           <= 1'b0;
      last_received_q <= 1'b0;
      last_sended_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      regs_q          <= regs_d;
      datasend_q      <= datasend_d;
      host_rdata_q    <= host_rdata_d;
      wr_valid_q      <= wr_valid_d;
      wr_index_q      <= wr_index_d;
      err_q           <= err_d;
      last_received_q <= last_received_d;
      last_sended_q   <= last_sended_d;
    end
  end

  assign datasend   = datasend_q;
  assign host_rdata = host_rdata_q;
  assign wr_valid   = wr_valid_q;
  assign wr_index   = wr_index_q;
  assign err        = err_q;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Directed bench for i2c_slave_regbank: instance a (WRAP=1, reg2 read-only)
// and instance b (WRAP=0, no read-only registers) share one stimulus.
module tb_i2c_slave_regbank;

  logic       clk = 1'b0;
  logic       reset;
  logic       transfer_start, transfer_rw;
  logic [7:0] datareceive;
  logic       received, sended;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       err_clr;

  logic [6:0] address_a, address_b;
  logic [7:0] datasend_a, datasend_b, host_rdata_a, host_rdata_b;
  logic       wr_valid_a, wr_valid_b, err_a, err_b;
  logic [3:0] wr_index_a, wr_index_b;

  int checks = 0;
  int errors = 0;

  logic       wv_a, wv_b;
  logic [3:0] wi_a, wi_b;
  logic [7:0] rd_a, rd_b;

  always #5 clk = ~clk;

  i2c_slave_regbank #(.RO_MASK(16'h0004)) dut_a (
    .clk(clk), .reset(reset), .address(address_a),
    .transfer_start(transfer_start), .transfer_rw(transfer_rw),
    .datareceive(datareceive), .received(received),
    .datasend(datasend_a), .sended(sended),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata_a), .wr_valid(wr_valid_a), .wr_index(wr_index_a),
    .err(err_a), .err_clr(err_clr)
  );

  i2c_slave_regbank #(.WRAP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .address(address_b),
    .transfer_start(transfer_start), .transfer_rw(transfer_rw),
    .datareceive(datareceive), .received(received),
    .datasend(datasend_b), .sended(sended),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata_b), .wr_valid(wr_valid_b), .wr_index(wr_index_b),
    .err(err_b), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic rw);
    transfer_start = 1'b1;
    transfer_rw    = rw;
    @(posedge clk);
    transfer_start = 1'b0;
    transfer_rw    = 1'b0;
  endtask

  // One received byte; wr_valid/wr_index captured in the cycle after the event.
  task automatic send_byte(input logic [7:0] b);
    datareceive = b;
    received    = 1'b1;
    @(posedge clk);
    wv_a = wr_valid_a; wi_a = wr_index_a;
    wv_b = wr_valid_b; wi_b = wr_index_b;
    received = 1'b0;
    host_we  = 1'b0;
    err_clr  = 1'b0;
    @(posedge clk);
  endtask

  task automatic send_ack();
    sended = 1'b1;
    @(posedge clk);
    sended = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(posedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a);
    host_addr = a;
    @(posedge clk);
    rd_a = host_rdata_a;
    rd_b = host_rdata_b;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    err_clr = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; transfer_start = 1'b0; transfer_rw = 1'b0;
    datareceive = '0; received = 1'b0; sended = 1'b0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);

    // Reset values
    chk("rst_address", 32'(address_a), 32'h50);
    chk("rst_datasend", 32'(datasend_a), 32'h00);
    chk("rst_host_rdata", 32'(host_rdata_a), 32'h00);
    chk("rst_wr_valid", 32'(wr_valid_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    reset = 1'b0;
    @(posedge clk);

    // Pointer write followed by two data bytes
    host_write(4'd5, 8'h5A);
    start(1'b0);
    send_byte(8'h03);
    chk("ptr_byte_no_wv", 32'(wv_a), 32'h0);
    send_byte(8'hAA);
    chk("wv_1", 32'(wv_a), 32'h1);
    chk("wi_1", 32'(wi_a), 32'h3);
    send_byte(8'hBB);
    chk("wv_2", 32'(wv_a), 32'h1);
    chk("wi_2", 32'(wi_a), 32'h4);
    chk("ptr_after_write", 32'(datasend_a), 32'h5A);
    host_read(4'd3);
    chk("reg3", 32'(rd_a), 32'hAA);
    host_read(4'd4);
    chk("reg4", 32'(rd_a), 32'hBB);

    // Pointer write then repeated-START read
    start(1'b0);
    send_byte(8'h04);
    start(1'b1);
    @(posedge clk);
    chk("read_first", 32'(datasend_a), 32'hBB);
    send_ack();
    chk("read_next", 32'(datasend_a), 32'h5A);

    // Wrap (a) versus saturate (b) at the last register
    start(1'b0);
    send_byte(8'h0F);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("wrap_wi_a", 32'(wi_a), 32'h0);
    chk("sat_wi_b", 32'(wi_b), 32'hF);
    chk("wrap_ptr_a", 32'(datasend_a), 32'h00);
    chk("sat_ptr_b", 32'(datasend_b), 32'h22);
    host_read(4'd15);
    chk("wrap_reg15_a", 32'(rd_a), 32'h11);
    chk("sat_reg15_b", 32'(rd_b), 32'h22);
    host_read(4'd0);
    chk("wrap_reg0_a", 32'(rd_a), 32'h22);
    chk("sat_reg0_b", 32'(rd_b), 32'h00);

    // Out-of-range pointer: error, pointer unchanged (a stays at 1)
    start(1'b0);
    send_byte(8'h20);
    chk("oor_err_a", 32'(err_a), 32'h1);
    chk("oor_err_b", 32'(err_b), 32'h1);
    send_byte(8'h77);
    host_read(4'd1);
    chk("oor_ptr_kept", 32'(rd_a), 32'h77);
    pulse_clr();
    chk("clr_err_a", 32'(err_a), 32'h0);

    // Read-only register write, with a simultaneous clear (set wins)
    start(1'b0);
    send_byte(8'h02);
    err_clr = 1'b1;
    send_byte(8'h99);
    chk("ro_no_wv_a", 32'(wv_a), 32'h0);
    chk("rw_wv_b", 32'(wv_b), 32'h1);
    chk("ro_err_set_wins", 32'(err_a), 32'h1);
    chk("clr_err_b", 32'(err_b), 32'h0);
    host_read(4'd2);
    chk("ro_reg2_a", 32'(rd_a), 32'h00);
    chk("rw_reg2_b", 32'(rd_b), 32'h99);
    pulse_clr();
    chk("clr_err_a2", 32'(err_a), 32'h0);

    // Host and I2C write the same register in the same cycle
    start(1'b0);
    send_byte(8'h01);
    host_we = 1'b1; host_addr = 4'd1; host_wdata = 8'h55;
    send_byte(8'h66);
    host_read(4'd1);
    chk("collide_reg1", 32'(rd_a), 32'h66);

    // Reset mid-write, then a byte without START is ignored
    start(1'b0);
    send_byte(8'h03);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    reset = 1'b0;
    send_byte(8'h44);
    chk("rst_mid_no_wv", 32'(wv_a), 32'h0);
    host_read(4'd3);
    chk("rst_mid_reg3", 32'(rd_a), 32'h00);
    host_read(4'd5);
    chk("rst_mid_reg5", 32'(rd_a), 32'h00);
    chk("rst_mid_datasend", 32'(datasend_a), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
